// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder controller (slave).
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (output start, a, b, ci, input busy, done, s, co);
  modport slave  (input start, a, b, ci, output busy, done, s, co);
endinterface

// File: rtl/full_adder_structure.sv
// Gate-level 1-bit full adder; the shared datapath the controller sequences.
module full_adder_structure (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic ab_x, ab_a, cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, ci);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, ci);
  or  g_o0 (co, ab_a, cx_a);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: runs one full adder LSB-first over WIDTH cycles,
// carry held in a flop, result registered at the end with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset_n,
  serial_adder_ctrl_if.slave bus
);
  import serial_adder_pkg::*;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_s_q, sh_s_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             fa_s, fa_co;

  full_adder_structure u_fa (
    .a  (sh_a_q[0]),
    .b  (sh_b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_a_d  = bus.a;
          sh_b_d  = bus.b;
          sh_s_d  = '0;
          carry_d = bus.ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        sh_s_d  = {fa_s, sh_s_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        // Final bit: publish the completed sum straight from the shift path.
        if (cnt_q == LAST) begin
          s_d     = {fa_s, sh_s_q[WIDTH-1:1]};
          co_d    = fa_co;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so all flops update from pre-edge values.
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FIN);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: directed WIDTH=8 vectors plus an exhaustive back-to-back WIDTH=4 sweep.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] last8, e8;
  logic [4:0] last4, e4;
  int         last_done4 = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: pop on done, otherwise results must hold while running.
  always @(negedge clk) begin
    if (!reset_n) last8 = '0;
    else if (bus8.done) begin
      check("done8_pending", 64'(exp8_q.size() != 0), 1);
      if (exp8_q.size() != 0) begin
        e8 = exp8_q.pop_front();
        check("sum8", {bus8.co, bus8.s}, e8);
        last8 = e8;
      end
    end else if (bus8.busy) check("hold8", {bus8.co, bus8.s}, last8);
  end

  always @(negedge clk) begin
    if (!reset_n) last4 = '0;
    else if (bus4.done) begin
      check("done4_pending", 64'(exp4_q.size() != 0), 1);
      if (exp4_q.size() != 0) begin
        e4 = exp4_q.pop_front();
        check("sum4", {bus4.co, bus4.s}, e4);
        last4 = e4;
      end
      if (last_done4 >= 0) check("done4_period", 64'(cyc - last_done4), 6);
      last_done4 = cyc;
    end else if (bus4.busy) check("hold4", {bus4.co, bus4.s}, last4);
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit poke);
    int n, nb;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.ci = ci; bus8.start = 1'b1;
    exp8_q.push_back({1'b0, a} + {1'b0, b} + 9'(ci));
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.ci = ~ci;
    n = 0; nb = 0;
    while (!bus8.done && n < 20) begin
      if (bus8.busy) nb++;
      if (poke && n == 3) begin bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; end
      if (poke && n == 4) bus8.start = 1'b0;
      @(posedge clk); #1; n++;
    end
    check("done_latency8", 64'(n), 8);
    check("busy_cycles8", 64'(nb), 8);
    check("busy_fin8", bus8.busy, 0);
    @(posedge clk); #1;
    check("done_pulse8", bus8.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [3:0] va, vb;
    logic       vc;

    reset_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_s", bus8.s, 8'h00);
    check("rst_co", bus8.co, 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", bus8.busy, 0);
    check("idle_done", bus8.done, 0);
    check("idle_sum", {bus8.co, bus8.s}, 9'h000);

    run8(8'h3C, 8'h42, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1, 1'b0);
    run8(8'h12, 8'h34, 1'b0, 1'b1);

    // Abort mid-run: nothing is pushed, so any done would be flagged by the monitor.
    @(negedge clk);
    bus8.a = 8'h0F; bus8.b = 8'h0F; bus8.ci = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_busy", bus8.busy, 1);
    check("abort_pre_sum", {bus8.co, bus8.s}, 9'h046);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus8.busy, 0);
    check("abort_sum", {bus8.co, bus8.s}, 9'h000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_idle_busy", bus8.busy, 0);
    run8(8'hC8, 8'h64, 1'b1, 1'b0);
    check("drain8", 64'(exp8_q.size()), 0);

    // Exhaustive 4-bit sweep with start held high.
    bus4.start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      {va, vb, vc} = 9'(i);
      bus4.a = va; bus4.b = vb; bus4.ci = vc;
      exp4_q.push_back(5'(va) + 5'(vb) + 5'(vc));
      t = 0;
      while (bus4.busy && t < 20) begin @(posedge clk); #1; t++; end
      while (!bus4.busy && t < 20) begin @(posedge clk); #1; t++; end
      check("accept4", bus4.busy, 1);
    end
    bus4.start = 1'b0;
    t = 0;
    while (exp4_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    check("drain4", 64'(exp4_q.size()), 0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It sequences a single 1-bit full adder (full_adder_structure) over WIDTH clock cycles, LSB first, holding the carry in a flip-flop between bits. A start/busy/done handshake lets the block sit between a simple requester (a switch/test FSM or a bench) and the shared 1-bit adder datapath. Results are registered and stay stable until the next accepted start.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).
CW, $clog2(WIDTH), bit-counter width (localparam, derived).

Ports:
clk      input   1      system clock, rising edge.
reset_n  input   1      asynchronous active-low reset.
start    input   1      request; sampled only in IDLE.
a        input   WIDTH  operand A, captured when start is accepted.
b        input   WIDTH  operand B, captured when start is accepted.
ci       input   1      carry-in, captured when start is accepted.
busy     output  1      high while in RUN.
done     output  1      one-cycle pulse: result valid.
s        output  WIDTH  registered sum.
co       output  1      registered carry-out.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; busy=0, done=0, s=0, co=0; operand shift regs, carry FF and counter all 0. Abort mid-RUN discards the operation, and no done is issued.
- States: IDLE, RUN, FIN (enum state_t).
- IDLE: start=1 at edge k -> load sh_a=a, sh_b=b, carry=ci, cnt=0, sh_s=0; go to RUN. start=0 -> stay.
- RUN: each edge, the full adder takes (sh_a[0], sh_b[0], carry).
  - sh_a and sh_b shift right by 1.
  - sh_s shifts right with the adder s entering at MSB.
  - carry <= adder co; cnt <= cnt+1.
  - When cnt==WIDTH-1 on that edge, go to FIN.
- FIN: one cycle. At the edge entering FIN, s <= final sh_s and co <= final carry. done=1 during FIN. Next edge -> IDLE.
- Latency: start sampled at edge k; busy=1 from after edge k through edge k+WIDTH; done=1 in the cycle after edge k+WIDTH (WIDTH+1 cycles from acceptance to done).
- busy = (state==RUN). done = (state==FIN), decoded from registered state, no combinational path from inputs.
- start while RUN or FIN is ignored, with no queueing. Back-to-back use: start held high through FIN is accepted at the first IDLE edge (minimum period WIDTH+2 cycles).
- a, b and ci may change freely after acceptance without affecting the operation.
- s and co hold the last result from FIN until the next FIN. They do not change during RUN.
- Arithmetic: {co,s} = a + b + ci, modulo 2^(WIDTH+1). Overflow appears only on co.

Decomposition:
- Package serial_adder_pkg: typedef enum logic [1:0] state_t {IDLE, RUN, FIN}. No other shared constants; WIDTH stays a module parameter.
- Sub-module: one existing full_adder_structure instance (ports a, b, ci, s, co) as the 1-bit datapath. The controller holds only FSM, counter, shift registers and carry FF.
- Bench: serial_adder_ctrl_tb, using the same $display table style as the existing adder benches and an exhaustive loop for WIDTH=4.

Test Plan:
- Reset: hold reset_n=0 -> busy=0, done=0, s=8'h00, co=0. Release, then idle 5 cycles -> outputs unchanged.
- a=8'h3C, b=8'h42, ci=0, start 1 cycle -> busy for 8 cycles, done pulse at cycle 9, s=8'h7E, co=0.
- a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1. Then a=8'hA5, b=8'h5A, ci=1 -> s=8'h00, co=1.
- Pulse start again 3 cycles into RUN with a=8'h01, b=8'h01 -> ignored. Result is the original operation's, and there is exactly one done pulse.
- Drop reset_n for 1 cycle mid-RUN -> immediate IDLE, s=0, co=0, no done. A new start then completes normally.
- WIDTH=4 exhaustive: all 512 (a,b,ci) combinations, start held high back-to-back -> every {co,s} == a+b+ci, and done pulses exactly every 6 cycles.
